// File: rtl/mdu_iter.sv
// mdu_iter: iterative 8-bit unsigned multiply/divide unit feeding the
// register-file write port. One operation in flight, fixed 8 iterations.
// Build option: define MDU_DIV_EN to compile in the restoring divider;
// without it, DIV/REM keep identical timing but write back zero.
module mdu_iter #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic              kill_i,
    output logic              busy_o,
    output logic              wb_en_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [WIDTH-1:0]  wb_data_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nx;
    logic [2:0]          cnt;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [WIDTH-1:0]    a_q;
    logic [2*WIDTH-1:0]  acc, acc_nx;
    logic [WIDTH:0]      msum;
    logic [WIDTH-1:0]    res;
    logic                accept, last;

    // Kill in IDLE blocks a simultaneous start; kill on the final edge wins
    // over completion so no write-back leaks out of a cancelled op.
    assign accept = (state == IDLE) && start_i && !kill_i;
    assign last   = (state == RUN) && (cnt == 3'd0) && !kill_i;
    assign busy_o = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (kill_i) state_nx = IDLE;
                     else if (cnt == 3'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shift-add step: low half starts as the multiplier and is consumed LSB
    // first while the product grows in from the top.
    always_comb begin
        msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        acc_nx = {msum, acc[WIDTH-1:1]};
    end

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0] b_q, quo, quo_nx, rem, rem_nx, sub;
    logic [WIDTH:0]   shifted;
    logic             ge;

    // Restoring step: quotient register starts as the dividend and shifts
    // its MSB into the partial remainder. The remainder always ends below
    // the divisor so only the shifted trial value needs the extra bit; a
    // zero divisor always subtracts, giving quotient 0xFF and remainder a.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        ge      = (shifted >= {1'b0, b_q});
        sub     = shifted[WIDTH-1:0] - b_q;
        rem_nx  = ge ? sub : shifted[WIDTH-1:0];
        quo_nx  = {quo[WIDTH-2:0], ge};
    end

    // Divider registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q <= '0;
            quo <= '0;
            rem <= '0;
        end else if (accept) begin
            b_q <= b_i;
            quo <= a_i;
            rem <= '0;
        end else if (state == RUN && !kill_i) begin
            quo <= quo_nx;
            rem <= rem_nx;
        end
    end

    // Result select from the values produced by the final iteration
    always_comb begin
        case (op_q)
            2'b00:   res = acc_nx[WIDTH-1:0];
            2'b01:   res = acc_nx[2*WIDTH-1:WIDTH];
            2'b10:   res = quo_nx;
            default: res = rem_nx;
        endcase
    end
`else
    // Result select; divide ops keep their timing but return zero
    always_comb begin
        case (op_q)
            2'b00:   res = acc_nx[WIDTH-1:0];
            2'b01:   res = acc_nx[2*WIDTH-1:WIDTH];
            default: res = '0;
        endcase
    end
`endif

    // Operand latch, multiplier accumulator and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            rd_q <= '0;
            a_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (accept) begin
            op_q <= op_i;
            rd_q <= rd_i;
            a_q  <= a_i;
            acc  <= {{WIDTH{1'b0}}, b_i};
            cnt  <= 3'd7;
        end else if (state == RUN && !kill_i) begin
            acc <= acc_nx;
            if (cnt != 3'd0) cnt <= cnt - 3'd1;
        end
    end

    // Write-back port: one-cycle strobe while in DONE, suppressed for r0;
    // address/data hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_data_o <= '0;
        end else begin
            wb_en_o <= last && (rd_q != '0);
            if (last) begin
                wb_addr_o <= rd_q;
                wb_data_o <= res;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboarded bench for mdu_iter: stimulus pushes expected write-backs
// (address, data, cycle) computed from plain arithmetic; a negedge monitor
// pops and compares every wb_en_o pulse.
module tb_mdu_iter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, kill_i;
    logic [1:0] op_i;
    logic [2:0] rd_i;
    logic [7:0] a_i, b_i;
    logic       busy_o, wb_en_o;
    logic [2:0] wb_addr_o;
    logic [7:0] wb_data_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    mdu_iter #(.WIDTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rd_i(rd_i),
        .a_i(a_i), .b_i(b_i), .kill_i(kill_i), .busy_o(busy_o),
        .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference result straight from the arithmetic definitions
    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'(a) * int'(b);
        case (op)
            2'b00: return p[7:0];
            2'b01: return p[15:8];
`ifdef MDU_DIV_EN
            2'b10: return (b == 0) ? 8'hFF : 8'(int'(a) / int'(b));
            default: return (b == 0) ? a : 8'(int'(a) % int'(b));
`else
            default: return 8'h00;
`endif
        endcase
    endfunction

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_exp(input logic [2:0] rd, input logic [7:0] data, input int at);
        exp_t e;
        e.addr = rd;
        e.data = data;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 40) begin
            step(1);
            n++;
        end
        check("idle_timeout", int'(busy_o), 0);
    endtask

    // One operation; kill_at=k>0 asserts kill before iteration edge Ek
    task automatic run_op(input logic [1:0] op, input logic [2:0] rd,
                          input logic [7:0] a, input logic [7:0] b, input int kill_at);
        int acc_cyc;
        wait_idle();
        start_i = 1'b1; op_i = op; rd_i = rd; a_i = a; b_i = b;
        step(1);
        start_i = 1'b0;
        op_i = 2'($urandom); rd_i = 3'($urandom); a_i = 8'($urandom); b_i = 8'($urandom);
        acc_cyc = cyc;
        check("busy_accept", int'(busy_o), 1);
        if (kill_at == 0) begin
            if (rd != 0) push_exp(rd, model(op, a, b), acc_cyc + 8);
            step(8);
            check("busy_done", int'(busy_o), 1);
            step(1);
            check("busy_end", int'(busy_o), 0);
        end else begin
            step(kill_at - 1);
            kill_i = 1'b1;
            step(1);
            kill_i = 1'b0;
            check("kill_idle", int'(busy_o), 0);
        end
    endtask

    // Monitor: every write-back strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && wb_en_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_wb: addr=%0d data=%h cycle=%0d", wb_addr_o, wb_data_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (wb_addr_o !== mon_e.addr || wb_data_o !== mon_e.data || cyc != int'(mon_e.cyc)) begin
                    bad++;
                    $display("FAIL wb: got addr=%0d data=%h cycle=%0d expected addr=%0d data=%h cycle=%0d",
                             wb_addr_o, wb_data_o, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc_cyc, k;
        logic [1:0] op;
        logic [7:0] b;
        rst = 1'b1; start_i = 1'b0; kill_i = 1'b0;
        op_i = '0; rd_i = '0; a_i = '0; b_i = '0;
        #1;
        check("rst_busy", int'(busy_o), 0);
        check("rst_wb_en", int'(wb_en_o), 0);
        check("rst_wb_addr", int'(wb_addr_o), 0);
        check("rst_wb_data", int'(wb_data_o), 0);
        step(2);
        rst = 1'b0;
        step(1);

        // Directed multiplies
        run_op(2'b00, 3'd3, 8'd13, 8'd11, 0);
        run_op(2'b01, 3'd3, 8'd13, 8'd11, 0);
        run_op(2'b01, 3'd4, 8'hFF, 8'hFF, 0);
        run_op(2'b00, 3'd4, 8'hFF, 8'hFF, 0);
        // Divides (expectation follows the build)
        run_op(2'b10, 3'd5, 8'd200, 8'd7, 0);
        run_op(2'b11, 3'd5, 8'd200, 8'd7, 0);
        run_op(2'b10, 3'd6, 8'd200, 8'd0, 0);
        run_op(2'b11, 3'd6, 8'd200, 8'd0, 0);
        // r0 destination: full busy window, no strobe
        run_op(2'b00, 3'd0, 8'd9, 8'd9, 0);
        // Kill at E4
        run_op(2'b00, 3'd2, 8'd13, 8'd11, 4);

        // start held high: accepts at E0 and E10 only
        wait_idle();
        start_i = 1'b1; op_i = 2'b00; rd_i = 3'd7; a_i = 8'd21; b_i = 8'd3;
        step(1);
        acc_cyc = cyc;
        push_exp(3'd7, model(2'b00, 8'd21, 8'd3), acc_cyc + 8);
        push_exp(3'd7, model(2'b00, 8'd21, 8'd3), acc_cyc + 18);
        step(9);
        check("held_gap", int'(busy_o), 0);
        step(1);
        check("held_reaccept", int'(busy_o), 1);
        start_i = 1'b0;
        wait_idle();

        // Kill in IDLE blocks acceptance
        start_i = 1'b1; kill_i = 1'b1; rd_i = 3'd1;
        step(1);
        start_i = 1'b0; kill_i = 1'b0;
        check("idle_kill_block", int'(busy_o), 0);

        // Reset mid-operation at E5
        start_i = 1'b1; op_i = 2'b00; rd_i = 3'd2; a_i = 8'd5; b_i = 8'd6;
        step(1);
        start_i = 1'b0;
        step(5);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_wb_en", int'(wb_en_o), 0);
        check("midrst_wb_addr", int'(wb_addr_o), 0);
        check("midrst_wb_data", int'(wb_data_o), 0);
        step(1);
        rst = 1'b0;
        run_op(2'b00, 3'd2, 8'd5, 8'd6, 0);

        // Randomized traffic with occasional zero divisors and kills
        for (int i = 0; i < 80; i++) begin
            op = 2'($urandom_range(0, 3));
            b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            k  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            run_op(op, 3'($urandom_range(0, 7)), 8'($urandom), b, k);
        end

        step(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
